mac_reg_bank: RTL

- Parametrised next-generation CPU register file for the Ethernet MAC.
- Provides:
  - NREG generic read/write control registers with per-register reset values.
  - A self-clearing command register with hardware completion.
  - A write-1-to-clear interrupt status register with mask and IRQ.
  - A 2*DW-bit statistics fetch engine with apply/grant handshake, shadow latch and timeout.
- Sits between the host bus (CSB/WRB/CA/CD) and the MAC/MIIM/RMON blocks.

---
 rtl/mac_reg_bank.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_reg_bank.sv
// Host-facing register bank for the Ethernet MAC. It holds the generic
// control registers, a self-clearing command register, the interrupt
// status/mask pair and a statistics fetch engine with a shadow latch.
module mac_reg_bank #(
  parameter int                   NREG     = 40,
  parameter int                   DW       = 16,
  parameter int                   AW       = 8,
  parameter logic [NREG*DW-1:0]   RST_VAL  = '0,
  parameter int                   EVT_N    = 8,
  parameter int                   SAW      = 6,
  parameter int                   STAT_TMO = 255
) (
  input  logic                 Clk_reg,
  input  logic                 Reset_n,
  input  logic                 CSB,
  input  logic                 WRB,
  input  logic [AW-1:0]        CA,
  input  logic [DW-1:0]        CD_in,
  output logic [DW-1:0]        CD_out,
  output logic [NREG*DW-1:0]   Reg_out,
  output logic [DW-1:0]        Cmd_out,
  input  logic [DW-1:0]        Cmd_done,
  input  logic                 Busy,
  input  logic [EVT_N-1:0]     Evt_in,
  output logic                 Irq,
  output logic [SAW-1:0]       Stat_rd_addr,
  output logic                 Stat_rd_apply,
  input  logic                 Stat_rd_grant,
  input  logic [2*DW-1:0]      Stat_rd_dout
);

  localparam logic [AW-1:0] A_CMD    = AW'(NREG);
  localparam logic [AW-1:0] A_ISR    = AW'(NREG + 1);
  localparam logic [AW-1:0] A_IMR    = AW'(NREG + 2);
  localparam logic [AW-1:0] A_SADDR  = AW'(NREG + 3);
  localparam logic [AW-1:0] A_SLO    = AW'(NREG + 4);
  localparam logic [AW-1:0] A_SHI    = AW'(NREG + 5);
  localparam logic [AW-1:0] A_STATUS = AW'(NREG + 6);
  localparam logic [15:0]   TMO_LAST = 16'(STAT_TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } stat_state_t;

  stat_state_t          state, state_nxt;
  logic                 wr_q;
  logic                 acc_wr, acc_rd, wr_stb;
  logic [NREG*DW-1:0]   regs;
  logic [DW-1:0]        cmd;
  logic [EVT_N:0]       isr, imr, isr_set, isr_clr;
  logic [SAW-1:0]       stat_addr;
  logic                 apply;
  logic [15:0]          timer;
  logic [2*DW-1:0]      shadow;
  logic                 stat_err;
  logic                 start_fetch, got_grant, tmo_hit;
  logic [DW-1:0]        rd_data;

  // A held chip select commits only on its first cycle.
  assign acc_wr = !CSB && !WRB;
  assign acc_rd = !CSB && WRB;
  assign wr_stb = acc_wr && !wr_q;

  assign Reg_out       = regs;
  assign Cmd_out       = cmd;
  assign Stat_rd_addr  = stat_addr;
  assign Stat_rd_apply = apply;

  // Remember the previous write phase to build the one-shot write strobe.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) wr_q <= 1'b0;
    else          wr_q <= acc_wr;
  end

  // Generic read/write registers with per-register reset values.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      regs <= RST_VAL;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_stb && (CA == AW'(i))) regs[i*DW +: DW] <= CD_in;
      end
    end
  end

  // Command register: completion pulses override a same-cycle host write.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd <= '0;
    end else if (wr_stb && (CA == A_CMD) && !Busy) begin
      cmd <= CD_in & ~Cmd_done;
    end else begin
      cmd <= cmd & ~Cmd_done;
    end
  end

  // Interrupt set/clear terms; a set always beats a write-1-to-clear.
  always_comb begin
    isr_set = {tmo_hit, Evt_in};
    if (wr_stb && (CA == A_ISR)) isr_clr = CD_in[EVT_N:0];
    else                         isr_clr = '0;
  end

  // Interrupt status, mask and the registered interrupt request.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      isr <= '0;
      imr <= '0;
      Irq <= 1'b0;
    end else begin
      isr <= (isr & ~isr_clr) | isr_set;
      if (wr_stb && (CA == A_IMR)) imr <= CD_in[EVT_N:0];
      Irq <= |(isr & imr);
    end
  end

  // Statistics fetch state register.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Statistics fetch next-state and completion decode.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    got_grant   = 1'b0;
    tmo_hit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_stb && (CA == A_SADDR)) begin
          start_fetch = 1'b1;
          state_nxt   = S_REQ;
        end else begin
          state_nxt   = S_IDLE;
        end
      end
      S_REQ: begin
        if (Stat_rd_grant) begin
          got_grant = 1'b1;
          state_nxt = S_DONE;
        end else if (timer == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_REQ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch datapath: request, wait timer and the atomically updated shadow.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n) begin
      stat_addr <= '0;
      apply     <= 1'b0;
      timer     <= 16'd0;
      shadow    <= '0;
      stat_err  <= 1'b0;
    end else if (start_fetch) begin
      stat_addr <= CD_in[SAW-1:0];
      apply     <= 1'b1;
      timer     <= 16'd0;
    end else if (got_grant) begin
      shadow    <= Stat_rd_dout;
      apply     <= 1'b0;
      stat_err  <= 1'b0;
    end else if (tmo_hit) begin
      shadow    <= '1;
      apply     <= 1'b0;
      stat_err  <= 1'b1;
    end else if (state == S_REQ) begin
      timer     <= timer + 16'd1;
    end
  end

  // Read mux; narrow fields are zero-extended, unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    case (CA)
      A_CMD:    rd_data = cmd;
      A_ISR:    rd_data[EVT_N:0] = isr;
      A_IMR:    rd_data[EVT_N:0] = imr;
      A_SADDR:  rd_data[SAW-1:0] = stat_addr;
      A_SLO:    rd_data = shadow[DW-1:0];
      A_SHI:    rd_data = shadow[2*DW-1:DW];
      A_STATUS: rd_data[2:0] = {Busy, stat_err, (state == S_REQ)};
      default:  rd_data = '0;
    endcase
    for (int i = 0; i < NREG; i++) begin
      rd_data = rd_data | ((CA == AW'(i)) ? regs[i*DW +: DW] : {DW{1'b0}});
    end
  end

  // Registered read data, held when no read access is in progress.
  always_ff @(posedge Clk_reg or negedge Reset_n) begin
    if (!Reset_n)    CD_out <= '0;
    else if (acc_rd) CD_out <= rd_data;
  end

endmodule
